// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared types and constants for the R2SDF FFT stage control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int DEF_DEPTH      = 8;
  localparam int DEF_LOG2_DEPTH = 3;

  localparam logic BFLY_BYPASS = 1'b0;
  localparam logic BFLY_SUM    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/r2sdf_stage_ctrl.sv
// ============================================================================
// Module      : r2sdf_stage_ctrl
// Description : Sample counter and FSM sequencing one R2SDF FFT stage
//               (delay-buffer shift, butterfly select, twiddle, flush).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module r2sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid,
  input  logic                  iFlush,
  output logic                  oBufEn,
  output logic                  oBflySel,
  output logic                  oTwEn,
  output logic [LOG2_DEPTH-1:0] oTwAddr,
  output logic                  oValid,
  output logic                  oSop,
  output logic                  oBusy,
  output logic                  oErr
);

  localparam int CW = LOG2_DEPTH + 1;
  localparam logic [CW-1:0]         CNT_ONE       = CW'(1);
  localparam logic [CW-1:0]         CNT_HALF      = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_FILL_LAST = CW'(DEPTH - 1);
  localparam logic [LOG2_DEPTH-1:0] FCNT_ONE      = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH-1:0] FCNT_LAST     = LOG2_DEPTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LOG2_DEPTH-1:0] fcnt_q, fcnt_d;
  logic                  err_q, err_d;

  // cnt is mod 2*DEPTH by width, so the RUN wrap needs no explicit compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = iFlush;
        if (iValid) begin
          state_d = FILL;
          cnt_d   = CNT_ONE;
        end
      end
      FILL: begin
        err_d = iFlush;
        if (iValid) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_FILL_LAST) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        err_d = iFlush && (cnt_q != '0);
        if (iValid) begin
          cnt_d = cnt_q + CNT_ONE;
        end else if (iFlush && (cnt_q == '0)) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        err_d  = iValid;
        fcnt_d = fcnt_q + FCNT_ONE;
        if (fcnt_q == FCNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  // Errors are registered so that no output depends on iFlush.
  always_comb begin
    oBufEn   = 1'b0;
    oBflySel = BFLY_BYPASS;
    oTwEn    = 1'b0;
    oTwAddr  = '0;
    oValid   = 1'b0;
    oSop     = 1'b0;
    oBusy    = 1'b0;
    oErr     = err_q;
    case (state_q)
      IDLE: begin
        oBufEn = iValid && iRst_n;
      end
      FILL: begin
        oBufEn = iValid;
      end
      RUN: begin
        oBufEn   = iValid;
        oValid   = iValid;
        oBflySel = cnt_q[LOG2_DEPTH] ? BFLY_SUM : BFLY_BYPASS;
        oTwEn    = iValid && !cnt_q[LOG2_DEPTH];
        oTwAddr  = cnt_q[LOG2_DEPTH-1:0];
        oSop     = iValid && (cnt_q == CNT_HALF);
      end
      FLUSH: begin
        oBufEn  = 1'b1;
        oValid  = 1'b1;
        oTwEn   = 1'b1;
        oBusy   = 1'b1;
        oTwAddr = fcnt_q;
      end
      default: begin
        oBufEn = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
